sw_pb_conditioner: RTL and testbench
====================================

Name: sw_pb_conditioner

Overview:
Front end that turns raw DE-board slide switches and pushbuttons into the clean single-cycle command pulses the clock control state machine consumes: set_time, stop_watch, set_alarm and strtStp. Each input channel is synchronised, debounced and edge-detected. The block also produces minute and hour increment pulses with press-and-hold auto-repeat for time and alarm adjustment. It sits between the board I/O pins and the clock control SM.

Parameters:
DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz); must be >= 2.
RPT_DLY, 25_000_000, hold time from the first increment pulse to the first auto-repeat pulse.
RPT_PER, 5_000_000, period between subsequent auto-repeat pulses.

Ports:
clk  input  1  50 MHz clock
rst  input  1  reset, synchronous, active-high
sw_raw  input  3  raw slide switches: [0] set_time, [1] stop_watch, [2] set_alarm; asynchronous to clk
key_raw_n  input  3  raw pushbuttons, active-low: [0] strtStp, [1] minute increment, [2] hour increment; asynchronous to clk
chng_en  input  1  increment enable; driven by en_time_chng OR en_alarm_chng
set_time  output  1  one-cycle pulse on debounced rise of sw_raw[0]
stop_watch  output  1  one-cycle pulse on debounced rise of sw_raw[1]
set_alarm  output  1  one-cycle pulse on debounced rise of sw_raw[2]
strtStp  output  1  one-cycle pulse on debounced press of key_raw_n[0]
min_inc  output  1  minute increment pulse, with auto-repeat
hr_inc  output  1  hour increment pulse, with auto-repeat
sw_db  output  3  debounced switch levels

Behaviour:
- Reset: all pulse outputs are 0; sw_db, sync flops, stable levels and all counters are 0; key stable level is "released"; settle timer is loaded.
- Synchroniser: each of the 6 raw inputs passes through 2 flops. Keys are inverted after synchronisation, so 1 means pressed.
- Debounce, one counter per channel:
  - While sync2 != stable, the counter increments.
  - When the counter reaches DB_CYCLES-1 and sync2 still differs, stable <= sync2 and the counter clears.
  - Any cycle with sync2 == stable clears the counter. A glitch shorter than DB_CYCLES never changes stable.
- Edge detect: each pulse output is a registered rise of its stable level and is high for exactly 1 cycle.
  - Latency: if edge E0 is the first edge that samples a new raw level, the pulse is high in the cycle following edge E(DB_CYCLES+2).
  - Switch falls and key releases generate no pulse.
- Post-reset settle: for DB_CYCLES+3 cycles after rst deasserts, stable levels track inputs but all pulses are suppressed. A switch already up at reset therefore never produces a spurious command.
- Auto-repeat, applied independently to min_inc and hr_inc:
  - States: IDLE, FIRST, REPEAT.
  - IDLE: on a debounced press with chng_en=1, emit 1 pulse, clear the repeat counter, go to FIRST.
  - FIRST: counter increments each cycle held. At RPT_DLY-1, emit a pulse, clear the counter, go to REPEAT.
  - REPEAT: at RPT_PER-1, emit a pulse and clear the counter.
  - Release, or chng_en=0, in any state: return to IDLE, counter = 0, no pulse.
  - A press while chng_en=0 is ignored. chng_en rising while the key is held does NOT start repeating; a fresh press is needed.
- Counter widths are $clog2 of the largest terminal value + 1. There is no wrap: counters clear at terminal count.
- Simultaneous events: channels are independent and several pulses may assert in the same cycle. Prioritisation belongs to the consumer SM.
- rst asserted mid-debounce or mid-repeat aborts the operation. No pulse is emitted in the reset cycle or during the following settle window.

Test Plan:
- DB_CYCLES=4, RPT_DLY=20, RPT_PER=8. After settle, raise sw_raw[0] and hold -> set_time high for exactly 1 cycle, following edge E6; sw_db[0]=1; no other pulse.
- Glitch: sw_raw[1] high for 3 cycles, then low -> stop_watch stays 0 and sw_db[1] stays 0. Then hold high for 10 cycles -> exactly 1 stop_watch pulse.
- Hold sw_raw[2]=1 through rst and release rst -> set_alarm never pulses; sw_db[2]=1 by the end of the settle window. Lower and raise again -> 1 pulse.
- chng_en=1, hold key_raw_n[1]=0 for 60 cycles after debounce -> min_inc pulses at relative cycles 0, 20, 28, 36, 44, 52. Release -> no further pulses; hr_inc stays 0.
- chng_en=0, press key_raw_n[2] -> hr_inc stays 0. Raise chng_en while still held -> still 0. Release and press again -> 1 pulse.
- Press key_raw_n[0] while raising sw_raw[0] in the same cycle -> strtStp and set_time pulse in the same cycle. Holding key_raw_n[0] for 100 cycles -> only 1 strtStp pulse (no auto-repeat).

Source files
------------

// File: rtl/sw_pb_conditioner.sv
// -----------------------------------------------------------------------------
// sw_pb_conditioner
//
// Purpose:
//   Turns raw board slide switches and pushbuttons into clean single-cycle
//   command pulses for the clock control state machine. Every input channel
//   is synchronised (2 flops), debounced (one counter per channel) and
//   edge-detected. The minute/hour buttons additionally drive press-and-hold
//   auto-repeat for time and alarm adjustment.
//
// Ports:
//   clk        - system clock (50 MHz)
//   rst        - synchronous, active-high reset
//   sw_raw     - raw switches [0] set_time [1] stop_watch [2] set_alarm (async)
//   key_raw_n  - raw active-low keys [0] strtStp [1] minute [2] hour (async)
//   chng_en    - increment enable (en_time_chng | en_alarm_chng)
//   set_time   - 1-cycle pulse on debounced rise of sw_raw[0]
//   stop_watch - 1-cycle pulse on debounced rise of sw_raw[1]
//   set_alarm  - 1-cycle pulse on debounced rise of sw_raw[2]
//   strtStp    - 1-cycle pulse on debounced press of key_raw_n[0]
//   min_inc    - minute increment pulse with auto-repeat
//   hr_inc     - hour increment pulse with auto-repeat
//   sw_db      - debounced switch levels
// -----------------------------------------------------------------------------
module sw_pb_conditioner #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int RPT_DLY   = 25_000_000,
    parameter int RPT_PER   = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_raw,
    input  logic [2:0] key_raw_n,
    input  logic       chng_en,
    output logic       set_time,
    output logic       stop_watch,
    output logic       set_alarm,
    output logic       strtStp,
    output logic       min_inc,
    output logic       hr_inc,
    output logic [2:0] sw_db
);

    localparam int DB_W    = $clog2(DB_CYCLES) + 1;
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;
    localparam int SET_W   = $clog2(DB_CYCLES + 3) + 1;

    localparam logic [DB_W-1:0]  DB_TERM  = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = 1;
    localparam logic [RPT_W-1:0] DLY_TERM = RPT_W'(RPT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_TERM = RPT_W'(RPT_PER - 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(DB_CYCLES + 3);
    localparam logic [SET_W-1:0] SET_ONE  = 1;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_FIRST  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Channel map: [2:0] switches, [5:3] keys (1 = pressed after inversion).
    logic [5:0]      sync1;
    logic [5:0]      sync2;
    logic [5:0]      level;
    logic [5:0]      stable;
    logic [5:0]      stable_d;
    logic [5:0]      rise;
    logic [DB_W-1:0] db_cnt [6];
    logic [SET_W-1:0] settle_cnt;
    logic            settled;

    // Auto-repeat: index 0 = minute key, index 1 = hour key.
    rpt_state_t       rpt_state     [2];
    rpt_state_t       rpt_state_nxt [2];
    logic [RPT_W-1:0] rpt_cnt       [2];
    logic [RPT_W-1:0] rpt_cnt_nxt   [2];
    logic [1:0]       rpt_emit;
    logic [1:0]       rpt_held;
    logic [1:0]       rpt_press;

    assign level     = {~sync2[5:3], sync2[2:0]};
    assign rise      = stable & ~stable_d;
    assign settled   = (settle_cnt == '0);
    assign sw_db     = stable[2:0];
    assign rpt_held  = stable[5:4];
    assign rpt_press = rise[5:4];

    // Synchroniser, per-channel debounce and post-reset settle timer.
    // stable_d keeps tracking during the settle window so that a level
    // accepted then is consumed silently instead of firing afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            stable_d   <= '0;
            settle_cnt <= SET_LOAD;
            for (int i = 0; i < 6; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= {key_raw_n, sw_raw};
            sync2    <= sync1;
            stable_d <= stable;
            if (!settled) begin
                settle_cnt <= settle_cnt - SET_ONE;
            end
            for (int i = 0; i < 6; i++) begin
                if (level[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TERM) begin
                    stable[i] <= level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    // Registered command pulses, held off until the settle window expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_time   <= 1'b0;
            stop_watch <= 1'b0;
            set_alarm  <= 1'b0;
            strtStp    <= 1'b0;
        end else begin
            set_time   <= rise[0] & settled;
            stop_watch <= rise[1] & settled;
            set_alarm  <= rise[2] & settled;
            strtStp    <= rise[3] & settled;
        end
    end

    // Auto-repeat FSM, next state. Losing the key or the enable aborts from
    // any state; only a fresh debounced press starts a sequence, so raising
    // chng_en while a key is already held does nothing.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rpt_state_nxt[i] = rpt_state[i];
            rpt_cnt_nxt[i]   = rpt_cnt[i];
            rpt_emit[i]      = 1'b0;
            if (!rpt_held[i] || !chng_en) begin
                rpt_state_nxt[i] = RPT_IDLE;
                rpt_cnt_nxt[i]   = '0;
            end else begin
                case (rpt_state[i])
                    RPT_IDLE: begin
                        if (rpt_press[i] && settled) begin
                            rpt_emit[i]      = 1'b1;
                            rpt_cnt_nxt[i]   = '0;
                            rpt_state_nxt[i] = RPT_FIRST;
                        end
                    end
                    RPT_FIRST: begin
                        if (rpt_cnt[i] == DLY_TERM) begin
                            rpt_emit[i]      = 1'b1;
                            rpt_cnt_nxt[i]   = '0;
                            rpt_state_nxt[i] = RPT_REPEAT;
                        end else begin
                            rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_ONE;
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_cnt[i] == PER_TERM) begin
                            rpt_emit[i]    = 1'b1;
                            rpt_cnt_nxt[i] = '0;
                        end else begin
                            rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_ONE;
                        end
                    end
                    default: begin
                        rpt_state_nxt[i] = RPT_IDLE;
                        rpt_cnt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Auto-repeat FSM, state register and registered increment pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rpt_state[i] <= RPT_IDLE;
                rpt_cnt[i]   <= '0;
            end
            min_inc <= 1'b0;
            hr_inc  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rpt_state[i] <= rpt_state_nxt[i];
                rpt_cnt[i]   <= rpt_cnt_nxt[i];
            end
            min_inc <= rpt_emit[0];
            hr_inc  <= rpt_emit[1];
        end
    end

endmodule

// File: tb/tb_sw_pb_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sw_pb_conditioner
//
// Bench for sw_pb_conditioner with DB_CYCLES=4, RPT_DLY=20, RPT_PER=8.
// A monitor logs every cycle in which any pulse output is high as
// {cycle, pulses}; scenario tasks push the pulses they expect when they
// drive stimulus and then pop and compare both queues.
// Pulse vector order: {hr_inc, min_inc, strtStp, set_alarm, stop_watch, set_time}.
// Inputs change 1 time unit after a rising edge captured as cycle a; the
// first edge that samples them is a+1, so a pulse shows up in cycle a+DB+3.
// -----------------------------------------------------------------------------
module tb_sw_pb_conditioner;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = DB + 3;
    localparam int W   = 38;

    logic       clk;
    logic       rst;
    logic [2:0] sw_raw;
    logic [2:0] key_raw_n;
    logic       chng_en;
    logic       set_time;
    logic       stop_watch;
    logic       set_alarm;
    logic       strtStp;
    logic       min_inc;
    logic       hr_inc;
    logic [2:0] sw_db;
    logic [5:0] pulses;

    int          cyc;
    int          n_cmp;
    int          n_err;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    sw_pb_conditioner #(
        .DB_CYCLES(DB),
        .RPT_DLY  (RD),
        .RPT_PER  (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .key_raw_n (key_raw_n),
        .chng_en   (chng_en),
        .set_time  (set_time),
        .stop_watch(stop_watch),
        .set_alarm (set_alarm),
        .strtStp   (strtStp),
        .min_inc   (min_inc),
        .hr_inc    (hr_inc),
        .sw_db     (sw_db)
    );

    assign pulses = {hr_inc, min_inc, strtStp, set_alarm, stop_watch, set_time};

    // Clock / cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (|pulses) obs_q.push_back({32'(cyc), pulses});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] e, o;
        rst = 1'b1; sw_raw = 3'b000; key_raw_n = 3'b111; chng_en = 1'b0;
        tick(3);
        n_cmp++;
        if (pulses !== 6'b0) begin
            n_err++;
            $display("FAIL reset_pulses: got %b want 000000", pulses);
        end
        n_cmp++;
        if (sw_db !== 3'b000) begin
            n_err++;
            $display("FAIL reset_sw_db: got %b want 000", sw_db);
        end
        obs_q.delete();
        rst = 1'b0;
        tick(12);
        n_cmp++;
        if (sw_db !== 3'b000) begin
            n_err++;
            $display("FAIL post_reset_sw_db: got %b want 000", sw_db);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_pulse: got cyc=%0d p=%b want cyc=%0d p=%b", o[37:6], o[5:0], e[37:6], e[5:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_stray: got %0d stray (first cyc=%0d p=%b) want 0", obs_q.size(), obs_q[0][37:6], obs_q[0][5:0]);
            obs_q.delete();
        end
    endtask

    task automatic test_set_time();
        logic [W-1:0] e, o;
        int a;
        a = cyc;
        sw_raw[0] = 1'b1;
        exp_q.push_back({32'(a + LAT), 6'b000001});
        tick(12);
        n_cmp++;
        if (sw_db !== 3'b001) begin
            n_err++;
            $display("FAIL set_time_sw_db: got %b want 001", sw_db);
        end
        sw_raw[0] = 1'b0;
        tick(10);
        n_cmp++;
        if (sw_db !== 3'b000) begin
            n_err++;
            $display("FAIL set_time_fall_sw_db: got %b want 000", sw_db);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL set_time_pulse: got cyc=%0d p=%b want cyc=%0d p=%b", o[37:6], o[5:0], e[37:6], e[5:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL set_time_stray: got %0d stray (first cyc=%0d p=%b) want 0", obs_q.size(), obs_q[0][37:6], obs_q[0][5:0]);
            obs_q.delete();
        end
    endtask

    task automatic test_glitch();
        logic [W-1:0] e, o;
        int a;
        int len;
        for (int k = 0; k < 3; k++) begin
            len = $urandom_range(1, DB - 1);
            sw_raw[1] = 1'b1;
            tick(len);
            sw_raw[1] = 1'b0;
            tick(10);
            n_cmp++;
            if (sw_db[1] !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_sw_db: len=%0d got %b want 0", len, sw_db[1]);
            end
        end
        a = cyc;
        sw_raw[1] = 1'b1;
        exp_q.push_back({32'(a + LAT), 6'b000010});
        tick(10);
        n_cmp++;
        if (sw_db[1] !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_hold_sw_db: got %b want 1", sw_db[1]);
        end
        sw_raw[1] = 1'b0;
        tick(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL glitch_pulse: got cyc=%0d p=%b want cyc=%0d p=%b", o[37:6], o[5:0], e[37:6], e[5:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_stray: got %0d stray (first cyc=%0d p=%b) want 0", obs_q.size(), obs_q[0][37:6], obs_q[0][5:0]);
            obs_q.delete();
        end
    endtask

    task automatic test_settle();
        logic [W-1:0] e, o;
        int a;
        rst = 1'b1;
        sw_raw[2] = 1'b1;
        tick(3);
        n_cmp++;
        if (sw_db !== 3'b000) begin
            n_err++;
            $display("FAIL settle_rst_sw_db: got %b want 000", sw_db);
        end
        rst = 1'b0;
        tick(LAT);
        n_cmp++;
        if (sw_db !== 3'b100) begin
            n_err++;
            $display("FAIL settle_sw_db: got %b want 100", sw_db);
        end
        tick(15);
        sw_raw[2] = 1'b0;
        tick(10);
        n_cmp++;
        if (sw_db !== 3'b000) begin
            n_err++;
            $display("FAIL settle_low_sw_db: got %b want 000", sw_db);
        end
        a = cyc;
        sw_raw[2] = 1'b1;
        exp_q.push_back({32'(a + LAT), 6'b000100});
        tick(12);
        sw_raw[2] = 1'b0;
        tick(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL settle_pulse: got cyc=%0d p=%b want cyc=%0d p=%b", o[37:6], o[5:0], e[37:6], e[5:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL settle_stray: got %0d stray (first cyc=%0d p=%b) want 0", obs_q.size(), obs_q[0][37:6], obs_q[0][5:0]);
            obs_q.delete();
        end
    endtask

    task automatic test_auto_repeat();
        logic [W-1:0] e, o;
        int a;
        int t;
        chng_en = 1'b1;
        a = cyc;
        key_raw_n[1] = 1'b0;
        // Pulses at relative 0, RD, RD+RP, ... while the key stays debounced-held.
        t = a + LAT;
        exp_q.push_back({32'(t), 6'b010000});
        t = t + RD;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({32'(t), 6'b010000});
            t = t + RP;
        end
        tick(LAT);
        n_cmp++;
        if (min_inc !== 1'b1) begin
            n_err++;
            $display("FAIL repeat_first: got %b want 1", min_inc);
        end
        // Release at relative 50: the debounced release lands before relative 60.
        tick(50);
        key_raw_n[1] = 1'b1;
        tick(45);
        chng_en = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL repeat_pulse: got cyc=%0d p=%b want cyc=%0d p=%b", o[37:6], o[5:0], e[37:6], e[5:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL repeat_stray: got %0d stray (first cyc=%0d p=%b) want 0", obs_q.size(), obs_q[0][37:6], obs_q[0][5:0]);
            obs_q.delete();
        end
    endtask

    task automatic test_chng_gate();
        logic [W-1:0] e, o;
        int b;
        chng_en = 1'b0;
        key_raw_n[2] = 1'b0;
        tick(12);
        chng_en = 1'b1;
        tick(40);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL gate_held: got %0d pulses (first cyc=%0d p=%b) want 0", obs_q.size(), obs_q[0][37:6], obs_q[0][5:0]);
            obs_q.delete();
        end
        key_raw_n[2] = 1'b1;
        tick(10);
        b = cyc;
        key_raw_n[2] = 1'b0;
        exp_q.push_back({32'(b + LAT), 6'b100000});
        tick(12);
        key_raw_n[2] = 1'b1;
        tick(40);
        chng_en = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL gate_pulse: got cyc=%0d p=%b want cyc=%0d p=%b", o[37:6], o[5:0], e[37:6], e[5:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL gate_stray: got %0d stray (first cyc=%0d p=%b) want 0", obs_q.size(), obs_q[0][37:6], obs_q[0][5:0]);
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, o;
        int a;
        a = cyc;
        key_raw_n[0] = 1'b0;
        sw_raw[0]    = 1'b1;
        exp_q.push_back({32'(a + LAT), 6'b001001});
        tick(100);
        key_raw_n[0] = 1'b1;
        sw_raw[0]    = 1'b0;
        tick(12);
        n_cmp++;
        if (sw_db !== 3'b000) begin
            n_err++;
            $display("FAIL b2b_sw_db: got %b want 000", sw_db);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b_pulse: got cyc=%0d p=%b want cyc=%0d p=%b", o[37:6], o[5:0], e[37:6], e[5:0]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_stray: got %0d stray (first cyc=%0d p=%b) want 0", obs_q.size(), obs_q[0][37:6], obs_q[0][5:0]);
            obs_q.delete();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; sw_raw = 3'b000; key_raw_n = 3'b111; chng_en = 1'b0;
        test_reset();
        test_set_time();
        test_glitch();
        test_settle();
        test_auto_repeat();
        test_chng_gate();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
